// File: rtl/ms_timer_arbiter_if.sv
// Requester-side bundle of the shared millisecond timer: level requests, per-requester
// durations, one-hot grant, done pulses, busy and the free-running 1 ms tick.
interface ms_timer_arbiter_if #(
   parameter int unsigned DUR_W = 16
);
   logic [2:0]       req;
   logic [DUR_W-1:0] dur0;
   logic [DUR_W-1:0] dur1;
   logic [DUR_W-1:0] dur2;
   logic [2:0]       gnt;
   logic [2:0]       done;
   logic             busy;
   logic             tick_1ms;

   modport master (
      output req, dur0, dur1, dur2,
      input  gnt, done, busy, tick_1ms
   );

   modport slave (
      input  req, dur0, dur1, dur2,
      output gnt, done, busy, tick_1ms
   );
endinterface

// File: rtl/ms_timer_arbiter.sv
// Shared cycle-exact millisecond delay timer, round-robin arbitrated between three requesters,
// plus an independent free-running 1 ms tick. All outputs are registered.
module ms_timer_arbiter #(
   parameter int unsigned CLK_PER_MS = 24000,
   parameter int unsigned DUR_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   ms_timer_arbiter_if.slave tmr_io
);

   localparam int unsigned SubW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [SubW-1:0]  SubMax = SubW'(CLK_PER_MS - 1);
   localparam logic [DUR_W-1:0] MsOne  = DUR_W'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [1:0]       last_q, last_d;
   logic [SubW-1:0]  sub_q, sub_d;
   logic [DUR_W-1:0] ms_q, ms_d;
   logic [2:0]       gnt_q, gnt_d;
   logic [2:0]       done_q, done_d;
   logic             busy_q, busy_d;
   logic [SubW-1:0]  tick_cnt_q, tick_cnt_d;
   logic             tick_q, tick_d;

   logic             win_vld;
   logic [1:0]       win_idx;
   logic [1:0]       start;
   logic [1:0]       cand;
   logic [DUR_W-1:0] win_dur;
   logic [2:0]       win_oh;

   // Prescaler runs regardless of the arbiter so the tick phase never shifts.
   always_comb begin
      tick_cnt_d = (tick_cnt_q == SubMax) ? '0 : tick_cnt_q + 1'b1;
      tick_d     = (tick_cnt_d == SubMax);
   end

   // Round-robin search starting just after the previous owner.
   always_comb begin
      win_vld = 1'b0;
      win_idx = last_q;
      cand    = 2'd0;
      start   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
      for (int k = 0; k < 3; k++) begin
         cand = 2'((int'(start) + k) % 3);
         if (!win_vld && tmr_io.req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      unique case (win_idx)
         2'd0:    win_dur = tmr_io.dur0;
         2'd1:    win_dur = tmr_io.dur1;
         default: win_dur = tmr_io.dur2;
      endcase
      win_oh = 3'b001 << win_idx;
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      sub_d   = sub_q;
      ms_d    = ms_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      busy_d  = busy_q;
      unique case (state_q)
         StIdle: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            if (win_vld) begin
               last_d = win_idx;
               sub_d  = '0;
               ms_d   = win_dur;
               gnt_d  = win_oh;
               busy_d = 1'b1;
               if (win_dur == '0) begin
                  state_d = StDone;
                  done_d  = win_oh;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (!tmr_io.req[last_q]) begin
               // Owner withdrew: release without a done pulse.
               state_d = StIdle;
               gnt_d   = '0;
               busy_d  = 1'b0;
               sub_d   = '0;
               ms_d    = '0;
            end else if (sub_q == SubMax) begin
               sub_d = '0;
               if (ms_q != '0) begin
                  ms_d = ms_q - MsOne;
               end
               if (ms_q == MsOne) begin
                  state_d = StDone;
                  done_d  = gnt_q;
               end
            end else begin
               sub_d = sub_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         last_q     <= 2'd2;
         sub_q      <= '0;
         ms_q       <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         sub_q      <= sub_d;
         ms_q       <= ms_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= tick_d;
      end
   end

   assign tmr_io.gnt      = gnt_q;
   assign tmr_io.done     = done_q;
   assign tmr_io.busy     = busy_q;
   assign tmr_io.tick_1ms = tick_q;

endmodule

// File: tb/tb_ms_timer_arbiter.sv
// Scoreboard bench for ms_timer_arbiter with CLK_PER_MS=4: stimulus queues expected
// grant/done/release events, a negedge monitor pops and compares them as they appear.
module tb_ms_timer_arbiter;

   localparam int unsigned P     = 4;
   localparam int unsigned DUR_W = 16;

   typedef struct {
      int         cyc;
      logic [2:0] gnt;
      logic [2:0] done;
      logic       busy;
   } ev_t;

   logic clk;
   logic rst;
   int   cyc;
   int   rel;
   int   n_checks;
   int   n_err;
   ev_t  exp_q[$];

   ms_timer_arbiter_if #(.DUR_W(DUR_W)) tmr_if ();

   ms_timer_arbiter #(
      .CLK_PER_MS(P),
      .DUR_W     (DUR_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .tmr_io(tmr_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_ev(input int c, input logic [2:0] g, input logic [2:0] d, input logic b);
      ev_t e;
      e.cyc  = c;
      e.gnt  = g;
      e.done = d;
      e.busy = b;
      exp_q.push_back(e);
   endtask

   // Request issued in IDLE cycle t: grant at t+1, done at t+1+dur*P, release one cycle later.
   task automatic expect_grant(input int t, input int who, input int dur);
      logic [2:0] oh;
      oh = 3'b001 << who;
      if (dur == 0) begin
         push_ev(t + 1, oh, oh, 1'b1);
      end else begin
         push_ev(t + 1, oh, 3'b000, 1'b1);
         push_ev(t + 1 + dur * int'(P), oh, oh, 1'b1);
      end
      push_ev(t + 2 + dur * int'(P), 3'b000, 3'b000, 1'b0);
   endtask

   // Monitor
   logic [2:0] pg;
   logic       pb;
   initial begin
      pg = '0;
      pb = 1'b0;
   end

   always @(negedge clk) begin
      ev_t e;
      logic exp_tick;
      if (!rst) begin
         n_checks++;
         if (tmr_if.gnt !== 3'b000 || tmr_if.done !== 3'b000 || tmr_if.busy !== 1'b0 ||
             tmr_if.tick_1ms !== 1'b0) begin
            n_err++;
            $display("FAIL reset_zero @%0d: gnt=%b done=%b busy=%b tick=%b, required all 0",
                     cyc, tmr_if.gnt, tmr_if.done, tmr_if.busy, tmr_if.tick_1ms);
         end
         pg = '0;
         pb = 1'b0;
      end else begin
         exp_tick = ((cyc - rel) % int'(P)) == int'(P) - 1;
         n_checks++;
         if (tmr_if.tick_1ms !== exp_tick) begin
            n_err++;
            $display("FAIL tick @%0d: got %b, required %b", cyc, tmr_if.tick_1ms, exp_tick);
         end
         if (tmr_if.gnt !== pg || tmr_if.done !== 3'b000 || tmr_if.busy !== pb) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_event @%0d: gnt=%b done=%b busy=%b", cyc,
                        tmr_if.gnt, tmr_if.done, tmr_if.busy);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.gnt !== tmr_if.gnt || e.done !== tmr_if.done ||
                   e.busy !== tmr_if.busy) begin
                  n_err++;
                  $display("FAIL event: got cyc=%0d gnt=%b done=%b busy=%b, required cyc=%0d gnt=%b done=%b busy=%b",
                           cyc, tmr_if.gnt, tmr_if.done, tmr_if.busy,
                           e.cyc, e.gnt, e.done, e.busy);
               end
            end
         end
         pg = tmr_if.gnt;
         pb = tmr_if.busy;
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Stimulus
   initial begin
      int t;
      n_checks    = 0;
      n_err       = 0;
      rel         = 0;
      rst         = 1'b0;
      tmr_if.req  = 3'b000;
      tmr_if.dur0 = '0;
      tmr_if.dur1 = '0;
      tmr_if.dur2 = '0;

      // Reset and tick, idle with no requests
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      rel = cyc;
      wait_to(rel + 12);

      // Round-robin 0,1,2,0 with dur=1 each
      t = cyc;
      tmr_if.dur0 = 1;
      tmr_if.dur1 = 1;
      tmr_if.dur2 = 1;
      tmr_if.req  = 3'b111;
      for (int k = 0; k < 4; k++) expect_grant(t + 6 * k, k % 3, 1);
      wait_to(t + 5);  tmr_if.req[0] = 1'b0;
      wait_to(t + 7);  tmr_if.req[0] = 1'b1;
      wait_to(t + 11); tmr_if.req[1] = 1'b0;
      wait_to(t + 17); tmr_if.req[2] = 1'b0;
      wait_to(t + 23); tmr_if.req[0] = 1'b0;
      wait_to(t + 27);

      // Single delay of 3 ms; dur change after grant must be ignored
      t = cyc;
      tmr_if.dur0 = 3;
      tmr_if.req  = 3'b001;
      expect_grant(t, 0, 3);
      wait_to(t + 3);  tmr_if.dur0 = 7;
      wait_to(t + 13); tmr_if.req = 3'b000;
      wait_to(t + 17);

      // Zero duration
      t = cyc;
      tmr_if.dur1 = 0;
      tmr_if.req  = 3'b010;
      expect_grant(t, 1, 0);
      wait_to(t + 1); tmr_if.req = 3'b000;
      wait_to(t + 4);

      // Abort of requester 0 with requester 1 pending
      t = cyc;
      tmr_if.dur0 = 5;
      tmr_if.req  = 3'b001;
      push_ev(t + 1, 3'b001, 3'b000, 1'b1);
      push_ev(t + 6, 3'b000, 3'b000, 1'b0);
      expect_grant(t + 6, 1, 2);
      wait_to(t + 2);  tmr_if.dur1 = 2; tmr_if.req = 3'b011;
      wait_to(t + 5);  tmr_if.req = 3'b010;
      wait_to(t + 15); tmr_if.req = 3'b000;
      wait_to(t + 19);

      // Reset mid-delay; requester 0 regains priority and a full duration
      t = cyc;
      tmr_if.dur0 = 3;
      tmr_if.dur1 = 1;
      tmr_if.req  = 3'b011;
      push_ev(t + 1, 3'b001, 3'b000, 1'b1);
      wait_to(t + 4);
      rst = 1'b0;
      exp_q.delete();
      wait_to(t + 6);
      rst = 1'b1;
      rel = cyc;
      expect_grant(t + 6, 0, 3);
      wait_to(t + 19); tmr_if.req = 3'b010;
      expect_grant(t + 20, 1, 1);
      wait_to(t + 25); tmr_if.req = 3'b000;
      wait_to(t + 30);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL leftover_events: %0d pending, required 0 (next cyc=%0d)",
                  exp_q.size(), exp_q[0].cyc);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
